// File: rtl/uart_host_controller.sv
// Host-side UART controller: TX FIFO paced by the UART baud tick, and an RX FIFO
// filled from HostInterrupt with the acknowledge handshake and sticky error flags.
module uart_host_controller #(
  parameter int FIFO_DEPTH  = 8,
  parameter int FRAME_TICKS = 10
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] TxWriteData,
  input  logic       TxWriteValid,
  output logic       TxWriteReady,
  output logic [7:0] RxReadData,
  output logic       RxReadValid,
  input  logic       RxReadReady,
  output logic [7:0] UartInputData,
  output logic       UartSendCommand,
  input  logic       UartTick,
  input  logic [7:0] UartOutputData,
  input  logic       UartHostInterrupt,
  output logic       UartHostAcknowledge,
  input  logic [2:0] UartErrors,
  output logic [2:0] ErrorStatus,
  input  logic       ErrorClear,
  output logic       RxOverflow,
  output logic       TxBusy
);

  localparam int PtrW  = $clog2(FIFO_DEPTH);
  localparam int CntW  = $clog2(FIFO_DEPTH + 1);
  localparam int TickW = $clog2(FRAME_TICKS + 1);

  typedef enum logic [1:0] {TX_IDLE, TX_ARM, TX_WAIT} txStateT;
  typedef enum logic [1:0] {RX_IDLE, RX_CAPTURE, RX_ACK} rxStateT;

  // ---------------- TX FIFO ----------------
  logic [7:0]      txMem [FIFO_DEPTH];
  logic [PtrW-1:0] txWrPtr, txRdPtr;
  logic [CntW-1:0] txCount;
  logic            txFull, txEmpty, txPush, txPop;

  assign txFull       = (txCount == CntW'(FIFO_DEPTH));
  assign txEmpty      = (txCount == '0);
  assign txPush       = TxWriteValid & ~txFull;
  assign TxWriteReady = ~txFull;

  always_ff @(posedge Clock) begin
    if (txPush) txMem[txWrPtr] <= TxWriteData;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      txWrPtr <= '0;
      txRdPtr <= '0;
      txCount <= '0;
    end else begin
      if (txPush) txWrPtr <= txWrPtr + PtrW'(1);
      if (txPop)  txRdPtr <= txRdPtr + PtrW'(1);
      if (txPush && !txPop)      txCount <= txCount + CntW'(1);
      else if (!txPush && txPop) txCount <= txCount - CntW'(1);
    end
  end

  // ---------------- TX FSM ----------------
  txStateT          txState, txStateNext;
  logic [TickW-1:0] tickCount, tickCountNext;
  logic             tickPrev, tickRise;

  assign tickRise = UartTick & ~tickPrev;

  always_comb begin
    txStateNext   = txState;
    tickCountNext = tickCount;
    txPop         = 1'b0;
    case (txState)
      TX_IDLE: begin
        if (!txEmpty) begin
          txPop       = 1'b1;
          txStateNext = TX_ARM;
        end
      end
      TX_ARM: begin
        if (tickRise) begin
          tickCountNext = '0;
          txStateNext   = TX_WAIT;
        end
      end
      TX_WAIT: begin
        // The arming edge is not part of the frame count.
        if (tickRise) begin
          if (tickCount == TickW'(FRAME_TICKS - 1)) txStateNext = TX_IDLE;
          else tickCountNext = tickCount + TickW'(1);
        end
      end
      default: txStateNext = TX_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      txState       <= TX_IDLE;
      tickCount     <= '0;
      tickPrev      <= 1'b0;
      UartInputData <= '0;
    end else begin
      txState   <= txStateNext;
      tickCount <= tickCountNext;
      tickPrev  <= UartTick;
      if (txPop) UartInputData <= txMem[txRdPtr];
    end
  end

  assign UartSendCommand = (txState == TX_ARM);
  assign TxBusy          = (txState != TX_IDLE) | ~txEmpty;

  // ---------------- RX FIFO ----------------
  logic [7:0]      rxMem [FIFO_DEPTH];
  logic [PtrW-1:0] rxWrPtr, rxRdPtr, rxRdPtrNext;
  logic [CntW-1:0] rxCount, rxCountNext;
  logic            rxFull, rxEmpty, rxPush, rxPop, rxCapture;

  assign rxFull      = (rxCount == CntW'(FIFO_DEPTH));
  assign rxEmpty     = (rxCount == '0);
  assign rxPush      = rxCapture & ~rxFull;
  assign rxPop       = RxReadReady & ~rxEmpty;
  assign RxReadValid = ~rxEmpty;

  always_comb begin
    rxRdPtrNext = rxPop ? rxRdPtr + PtrW'(1) : rxRdPtr;
    rxCountNext = rxCount;
    if (rxPush && !rxPop)      rxCountNext = rxCount + CntW'(1);
    else if (!rxPush && rxPop) rxCountNext = rxCount - CntW'(1);
  end

  always_ff @(posedge Clock) begin
    if (rxPush) rxMem[rxWrPtr] <= UartOutputData;
  end

  // Head register bypasses the incoming byte when it lands in the next head slot.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rxWrPtr    <= '0;
      rxRdPtr    <= '0;
      rxCount    <= '0;
      RxReadData <= '0;
    end else begin
      if (rxPush) rxWrPtr <= rxWrPtr + PtrW'(1);
      rxRdPtr <= rxRdPtrNext;
      rxCount <= rxCountNext;
      if (rxCountNext == '0)                 RxReadData <= '0;
      else if (rxPush && rxWrPtr == rxRdPtrNext) RxReadData <= UartOutputData;
      else                                   RxReadData <= rxMem[rxRdPtrNext];
    end
  end

  // ---------------- RX FSM ----------------
  rxStateT rxState, rxStateNext;
  logic    intMeta, intSync;

  always_comb begin
    rxStateNext = rxState;
    case (rxState)
      RX_IDLE:    if (intSync) rxStateNext = RX_CAPTURE;
      RX_CAPTURE: rxStateNext = RX_ACK;
      RX_ACK:     if (!intSync) rxStateNext = RX_IDLE;
      default:    rxStateNext = RX_IDLE;
    endcase
  end

  assign rxCapture           = (rxState == RX_CAPTURE);
  assign UartHostAcknowledge = (rxState == RX_ACK);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rxState     <= RX_IDLE;
      intMeta     <= 1'b0;
      intSync     <= 1'b0;
      ErrorStatus <= '0;
      RxOverflow  <= 1'b0;
    end else begin
      rxState <= rxStateNext;
      intMeta <= UartHostInterrupt;
      intSync <= intMeta;
      // A capture in the same cycle as ErrorClear keeps the newly captured flags.
      if (rxCapture)       ErrorStatus <= (ErrorClear ? 3'b000 : ErrorStatus) | UartErrors;
      else if (ErrorClear) ErrorStatus <= '0;
      if (rxCapture && rxFull) RxOverflow <= 1'b1;
      else if (ErrorClear)     RxOverflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_host_controller.sv
// Scoreboard bench for uart_host_controller: expected TX/RX bytes are queued at
// stimulus time and compared by monitors when the DUT presents them.
module tb_uart_host_controller;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic [7:0] TxWriteData = '0;
  logic       TxWriteValid = 1'b0;
  logic       TxWriteReady;
  logic [7:0] RxReadData;
  logic       RxReadValid;
  logic       RxReadReady = 1'b0;
  logic [7:0] UartInputData;
  logic       UartSendCommand;
  logic       UartTick = 1'b0;
  logic [7:0] UartOutputData = '0;
  logic       UartHostInterrupt = 1'b0;
  logic       UartHostAcknowledge;
  logic [2:0] UartErrors = '0;
  logic [2:0] ErrorStatus;
  logic       ErrorClear = 1'b0;
  logic       RxOverflow;
  logic       TxBusy;

  int errors = 0;
  int checks = 0;
  logic [7:0] txExpQ[$];
  logic [7:0] rxExpQ[$];
  bit tickEn = 1'b0;
  int tickDiv = 0;

  uart_host_controller #(.FIFO_DEPTH(8), .FRAME_TICKS(10)) dut (
    .Clock(clk), .Reset(rstN),
    .TxWriteData(TxWriteData), .TxWriteValid(TxWriteValid), .TxWriteReady(TxWriteReady),
    .RxReadData(RxReadData), .RxReadValid(RxReadValid), .RxReadReady(RxReadReady),
    .UartInputData(UartInputData), .UartSendCommand(UartSendCommand), .UartTick(UartTick),
    .UartOutputData(UartOutputData), .UartHostInterrupt(UartHostInterrupt),
    .UartHostAcknowledge(UartHostAcknowledge), .UartErrors(UartErrors),
    .ErrorStatus(ErrorStatus), .ErrorClear(ErrorClear), .RxOverflow(RxOverflow), .TxBusy(TxBusy)
  );

  initial forever #5 clk = ~clk;

  // Free-running tick: one-cycle pulse every 4 cycles while enabled.
  initial forever begin
    @(posedge clk); #1;
    if (tickEn) begin
      tickDiv++;
      UartTick = (tickDiv % 4 == 0);
    end
  end

  // Scoreboard monitors.
  initial begin : monitor
    logic sendPrev;
    logic [7:0] e;
    sendPrev = 1'b0;
    forever begin
      @(negedge clk);
      if (UartSendCommand && !sendPrev) begin
        checks++;
        if (txExpQ.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected: sent %02h, required no transmission", UartInputData);
        end else begin
          e = txExpQ.pop_front();
          if (UartInputData !== e) begin
            errors++;
            $display("FAIL tx_data: got %02h, required %02h", UartInputData, e);
          end else $display("tx byte %02h sent", UartInputData);
        end
      end
      sendPrev = UartSendCommand;
      if (RxReadReady && RxReadValid) begin
        checks++;
        if (rxExpQ.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected: read %02h, required empty", RxReadData);
        end else begin
          e = rxExpQ.pop_front();
          if (RxReadData !== e) begin
            errors++;
            $display("FAIL rx_data: got %02h, required %02h", RxReadData, e);
          end else $display("rx byte %02h read", RxReadData);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic stopTicks();
    tickEn = 1'b0;
    repeat (2) @(posedge clk);
    #2 UartTick = 1'b0;
  endtask

  task automatic tickPulse();
    @(posedge clk); #1 UartTick = 1'b1;
    @(posedge clk); #1 UartTick = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({TxWriteReady, RxReadValid, RxReadData, UartSendCommand, UartHostAcknowledge,
         UartInputData, ErrorStatus, RxOverflow, TxBusy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0,
         8'h00, 3'b000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: rdy=%b val=%b rd=%02h send=%b ack=%b in=%02h err=%b ovf=%b busy=%b, required 1 0 00 0 0 00 000 0 0",
               TxWriteReady, RxReadValid, RxReadData, UartSendCommand, UartHostAcknowledge,
               UartInputData, ErrorStatus, RxOverflow, TxBusy);
    end
    @(posedge clk); #1 rstN = 1'b1;
    tickEn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if ({TxWriteReady, RxReadValid, UartSendCommand, ErrorStatus} !== {1'b1, 1'b0, 1'b0, 3'b000}) begin
        errors++;
        $display("FAIL idle_cycle%0d: rdy=%b val=%b send=%b err=%b, required 1 0 0 000",
                 i, TxWriteReady, RxReadValid, UartSendCommand, ErrorStatus);
      end
    end
    stopTicks();
    $display("reset/idle done");
  endtask

  task automatic test_single_tx();
    @(posedge clk); #1 TxWriteData = 8'hA5; TxWriteValid = 1'b1;
    txExpQ.push_back(8'hA5);
    @(posedge clk); #1 TxWriteValid = 1'b0;
    @(negedge clk);
    checks++;
    if (UartSendCommand !== 1'b0) begin
      errors++; $display("FAIL tx_latency_n1: send=%b, required 0", UartSendCommand);
    end
    @(negedge clk);
    checks++;
    if (UartSendCommand !== 1'b1) begin
      errors++; $display("FAIL tx_latency_n2: send=%b, required 1", UartSendCommand);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (UartSendCommand !== 1'b1) begin
      errors++; $display("FAIL tx_arm_hold: send=%b, required 1", UartSendCommand);
    end
    tickPulse();
    @(negedge clk);
    checks++;
    if ({UartSendCommand, UartInputData, TxBusy} !== {1'b0, 8'hA5, 1'b1}) begin
      errors++;
      $display("FAIL tx_armed_edge: send=%b in=%02h busy=%b, required 0 a5 1", UartSendCommand, UartInputData, TxBusy);
    end
    for (int i = 1; i <= 10; i++) begin
      tickPulse();
      @(negedge clk);
      checks++;
      if (i < 10 && {TxBusy, UartInputData, UartSendCommand} !== {1'b1, 8'hA5, 1'b0}) begin
        errors++;
        $display("FAIL tx_frame_rise%0d: busy=%b in=%02h send=%b, required 1 a5 0", i, TxBusy, UartInputData, UartSendCommand);
      end else if (i == 10 && TxBusy !== 1'b0) begin
        errors++;
        $display("FAIL tx_frame_end: busy=%b, required 0", TxBusy);
      end
    end
    $display("single tx done");
  endtask

  task automatic test_tx_fifo_full();
    bit done;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      checks++;
      if (TxWriteReady !== 1'b1) begin
        errors++; $display("FAIL tx_ready_before_%0d: got %b, required 1", i, TxWriteReady);
      end
      @(posedge clk); #1 TxWriteData = 8'(i); TxWriteValid = 1'b1;
      txExpQ.push_back(8'(i));
    end
    @(posedge clk); #1 TxWriteValid = 1'b0;
    @(negedge clk);
    checks++;
    if ({TxWriteReady, TxBusy, UartSendCommand, UartInputData} !== {1'b0, 1'b1, 1'b1, 8'h01}) begin
      errors++;
      $display("FAIL tx_full: rdy=%b busy=%b send=%b in=%02h, required 0 1 1 01", TxWriteReady, TxBusy, UartSendCommand, UartInputData);
    end
    // Rejected write while full must never be transmitted.
    @(posedge clk); #1 TxWriteData = 8'hFF; TxWriteValid = 1'b1;
    @(posedge clk); #1 TxWriteValid = 1'b0;
    tickEn = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      if (!TxBusy && txExpQ.size() == 0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL tx_drain: %0d bytes pending busy=%b, required 0 pending", txExpQ.size(), TxBusy);
    end
    stopTicks();
    repeat (50) @(negedge clk);
    checks++;
    if ({TxWriteReady, TxBusy} !== 2'b10) begin
      errors++; $display("FAIL tx_after_drain: rdy=%b busy=%b, required 1 0", TxWriteReady, TxBusy);
    end
    $display("tx fifo full done");
  endtask

  task automatic test_rx_single();
    UartOutputData = 8'h3C; UartErrors = 3'b010;
    @(posedge clk); #1 UartHostInterrupt = 1'b1;
    rxExpQ.push_back(8'h3C);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 3) begin
        checks++;
        if ({UartHostAcknowledge, RxReadValid} !== 2'b00) begin
          errors++; $display("FAIL rx_early: ack=%b val=%b, required 0 0", UartHostAcknowledge, RxReadValid);
        end
      end
    end
    checks++;
    if ({UartHostAcknowledge, RxReadValid, RxReadData, ErrorStatus} !== {1'b1, 1'b1, 8'h3C, 3'b010}) begin
      errors++;
      $display("FAIL rx_latency4: ack=%b val=%b rd=%02h err=%b, required 1 1 3c 010",
               UartHostAcknowledge, RxReadValid, RxReadData, ErrorStatus);
    end
    UartErrors = 3'b000;
    repeat (6) @(negedge clk);
    @(posedge clk); #1 UartHostInterrupt = 1'b0;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (k == 0 || k == 3) begin
        checks++;
        if (UartHostAcknowledge !== (k == 0)) begin
          errors++; $display("FAIL rx_ack_drop_k%0d: ack=%b, required %0d", k, UartHostAcknowledge, k == 0);
        end
      end
    end
    @(posedge clk); #1 RxReadReady = 1'b1;
    @(posedge clk); #1 RxReadReady = 1'b0;
    @(negedge clk);
    checks++;
    if ({RxReadValid, RxReadData, ErrorStatus} !== {1'b0, 8'h00, 3'b010}) begin
      errors++; $display("FAIL rx_one_capture: val=%b rd=%02h err=%b, required 0 00 010", RxReadValid, RxReadData, ErrorStatus);
    end
    @(posedge clk); #1 ErrorClear = 1'b1;
    @(posedge clk); #1 ErrorClear = 1'b0;
    @(negedge clk);
    checks++;
    if (ErrorStatus !== 3'b000) begin
      errors++; $display("FAIL err_clear: got %b, required 000", ErrorStatus);
    end
    $display("rx single done");
  endtask

  task automatic rxInterrupt(input logic [7:0] data, input string tag);
    bit got;
    UartOutputData = data;
    @(posedge clk); #1 UartHostInterrupt = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      @(negedge clk);
      if (UartHostAcknowledge) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL %s_ack_rise: ack=%b, required 1 within 12 cycles", tag, UartHostAcknowledge);
    end
    @(posedge clk); #1 UartHostInterrupt = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      @(negedge clk);
      if (!UartHostAcknowledge) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL %s_ack_fall: ack=%b, required 0 within 12 cycles", tag, UartHostAcknowledge);
    end
  endtask

  task automatic test_rx_overflow();
    bit done;
    UartErrors = 3'b000;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) rxExpQ.push_back(8'h10 + 8'(i));
      rxInterrupt(8'h10 + 8'(i), "ovf");
      if (i == 7) begin
        checks++;
        if ({RxOverflow, RxReadValid, RxReadData} !== {1'b0, 1'b1, 8'h10}) begin
          errors++; $display("FAIL rx_eight_stored: ovf=%b val=%b rd=%02h, required 0 1 10", RxOverflow, RxReadValid, RxReadData);
        end
      end
    end
    @(negedge clk);
    checks++;
    if ({RxOverflow, RxReadData} !== {1'b1, 8'h10}) begin
      errors++; $display("FAIL rx_overflow: ovf=%b rd=%02h, required 1 10", RxOverflow, RxReadData);
    end
    // ErrorClear lands exactly on another overflowing capture cycle.
    UartOutputData = 8'hEE;
    @(posedge clk); #1 UartHostInterrupt = 1'b1;
    repeat (3) @(posedge clk);
    #1 ErrorClear = 1'b1;
    @(posedge clk); #1 ErrorClear = 1'b0;
    @(negedge clk);
    checks++;
    if ({RxOverflow, UartHostAcknowledge} !== 2'b11) begin
      errors++; $display("FAIL ovf_set_wins: ovf=%b ack=%b, required 1 1", RxOverflow, UartHostAcknowledge);
    end
    @(posedge clk); #1 ErrorClear = 1'b1;
    @(posedge clk); #1 ErrorClear = 1'b0;
    @(negedge clk);
    checks++;
    if (RxOverflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: got %b, required 0", RxOverflow);
    end
    @(posedge clk); #1 UartHostInterrupt = 1'b0;
    repeat (5) @(posedge clk);
    #1 RxReadReady = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clk);
      if (!RxReadValid) done = 1'b1;
    end
    @(posedge clk); #1 RxReadReady = 1'b0;
    checks++;
    if (!done || rxExpQ.size() != 0) begin
      errors++; $display("FAIL rx_drain: %0d bytes unread val=%b, required 0", rxExpQ.size(), RxReadValid);
    end
    $display("rx overflow done");
  endtask

  task automatic test_reset_mid();
    bit got;
    @(posedge clk); #1 TxWriteData = 8'h5A; TxWriteValid = 1'b1;
    txExpQ.push_back(8'h5A);
    @(posedge clk); #1 TxWriteValid = 1'b0;
    repeat (3) @(negedge clk);
    tickPulse();
    tickPulse();
    @(posedge clk); #1 TxWriteData = 8'h77; TxWriteValid = 1'b1;
    @(posedge clk); #1 TxWriteValid = 1'b0;
    UartOutputData = 8'h99;
    @(posedge clk); #1 UartHostInterrupt = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      @(negedge clk);
      if (UartHostAcknowledge) got = 1'b1;
    end
    checks++;
    if (!got || {TxBusy, UartInputData, RxReadValid} !== {1'b1, 8'h5A, 1'b1}) begin
      errors++;
      $display("FAIL pre_reset: ack=%b busy=%b in=%02h val=%b, required 1 1 5a 1", UartHostAcknowledge, TxBusy, UartInputData, RxReadValid);
    end
    #2 rstN = 1'b0;
    #1;
    checks++;
    if ({UartSendCommand, UartHostAcknowledge, UartInputData, TxWriteReady, RxReadValid, RxReadData, TxBusy}
        !== {1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: send=%b ack=%b in=%02h rdy=%b val=%b rd=%02h busy=%b, required 0 0 00 1 0 00 0",
               UartSendCommand, UartHostAcknowledge, UartInputData, TxWriteReady, RxReadValid, RxReadData, TxBusy);
    end
    UartHostInterrupt = 1'b0;
    txExpQ.delete();
    rxExpQ.delete();
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (UartSendCommand || UartHostAcknowledge || TxBusy || RxReadValid) got = 1'b1;
    end
    checks++;
    if (got) begin
      errors++; $display("FAIL post_reset_idle: activity after aborted reset, required none");
    end
    $display("mid-operation reset done");
  endtask

  initial begin
    test_reset();
    test_single_tx();
    test_tx_fifo_full();
    test_rx_single();
    test_rx_overflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
